// File: rtl/sm_fifo_width_down.sv
// sm_fifo_width_down
// Drains DW-bit words from a show-ahead FIFO read port and re-emits each one
// as DW/OW narrower beats on a valid/ready stream, least-significant slice
// first, sustaining one beat per clock when the FIFO has data and the sink is
// ready. Also counts fully transmitted words.
module sm_fifo_width_down #(
    parameter int DW = 32,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd_en,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic          m_last,
    output logic [CW-1:0] words_done,
    output logic          busy
);

    localparam int RATIO = DW / OW;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] words_q, words_d;

    logic take;
    logic last_take;

    // Held word split into its output slices; beat_q selects the current one.
    // Only registered state feeds the output mux, so fifo_data never reaches
    // an output combinationally.
    logic [OW-1:0] slice_w [RATIO];

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slice
            assign slice_w[gi] = hold_q[gi*OW +: OW];
        end
    endgenerate

    assign m_valid    = (state_q == SEND);
    assign take       = m_valid & m_ready;
    assign last_take  = take & (beat_q == LAST_BEAT);
    // Pop when idle, or in the same cycle the final beat leaves so the next
    // word follows with no bubble. Gated by rstn so no pop happens in reset.
    assign fifo_rd_en = rstn & ~fifo_empty & ((state_q == EMPTY) | last_take);

    assign m_data     = slice_w[beat_q];
    assign m_last     = m_valid & (beat_q == LAST_BEAT);
    assign busy       = m_valid;
    assign words_done = words_q;

    // Next-state logic: load on pop, advance beat on take, otherwise hold.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        words_d = words_q;
        case (state_q)
            EMPTY: begin
                if (fifo_rd_en) begin
                    hold_d  = fifo_data;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (last_take) begin
                    words_d = words_q + CW'(1);
                    if (fifo_rd_en) begin
                        hold_d = fifo_data;
                        beat_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (take) begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State registers with synchronous active-low reset; a reset mid-word
    // simply discards the held word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            beat_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
            words_q <= words_d;
        end
    end

endmodule

// File: tb/tb_sm_fifo_width_down.sv
// Bench for sm_fifo_width_down: table-driven directed vectors, hand-written
// reset/wrap sequences and randomized traffic against a byte scoreboard.
// A second instance with CW=4 shares all inputs to observe counter wrap.
module tb_sm_fifo_width_down;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rd_en, fifo_rd_en_w;
    logic        m_valid, m_valid_w;
    logic        m_ready;
    logic [7:0]  m_data, m_data_w;
    logic        m_last, m_last_w;
    logic [15:0] words_done;
    logic [3:0]  words_done_w;
    logic        busy, busy_w;

    always #5 clk = ~clk;

    sm_fifo_width_down #(.DW(32), .OW(8), .CW(16)) dut (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .words_done(words_done), .busy(busy)
    );

    sm_fifo_width_down #(.DW(32), .OW(8), .CW(4)) u_wrap (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en_w), .m_valid(m_valid_w), .m_ready(m_ready),
        .m_data(m_data_w), .m_last(m_last_w), .words_done(words_done_w), .busy(busy_w)
    );

    int tests = 0;
    int fails = 0;

    // FIFO model: show-ahead head word, popped on the edge after rd_en seen.
    logic [31:0] fq[$];
    logic        s_rd;

    typedef struct {
        bit          rst;
        bit          push;
        logic [31:0] pdata;
        logic        ready;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rd;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit push, logic [31:0] pdata, logic ready,
                                logic v, logic [7:0] d, logic l, logic rd, logic [15:0] wd);
        vec_t t;
        t.rst = rst; t.push = push; t.pdata = pdata; t.ready = ready;
        t.v = v; t.d = d; t.l = l; t.rd = rd; t.wd = wd;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic update_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 32'h0 : fq[0];
    endtask

    task automatic push_word(logic [31:0] w);
        fq.push_back(w);
        update_fifo();
    endtask

    task automatic sample();
        @(negedge clk);
        s_rd = fifo_rd_en;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (s_rd && fq.size() > 0) void'(fq.pop_front());
        update_fifo();
    endtask

    // One reset cycle with a word pending to confirm rd_en is gated, then the
    // FIFO is flushed (it shares rstn) and the post-reset outputs are checked.
    task automatic do_reset();
        rstn = 1'b0;
        m_ready = 1'b1;
        fq.delete();
        push_word(32'hDEADBEEF);
        sample();
        check("rst_rd_en_gated", {31'b0, fifo_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fq.delete();
        update_fifo();
        sample();
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        check("rst_last", {31'b0, m_last}, 32'd0);
        check("rst_data", {24'b0, m_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_words", {16'b0, words_done}, 32'd0);
        check("rst_words_w", {28'b0, words_done_w}, 32'd0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        advance();
    endtask

    initial begin
        rstn = 1'b0;
        m_ready = 1'b0;
        update_fifo();

        // ---------------- vector table ----------------
        // single word, m_ready high
        vecs.push_back(mk(1, 1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h33, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h44, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 0, 8'h00, 0, 0, 1));
        // back-to-back, second pop coincides with the DD take
        vecs.push_back(mk(1, 1, 32'hDDCCBBAA, 1, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h04030201, 1, 1, 8'hAA, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'hBB, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'hCC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'hDD, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h01, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h02, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h03, 0, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h04, 1, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0, 1, 0, 8'h00, 0, 0, 2));
        // backpressure: three stalled cycles on 0x22
        vecs.push_back(mk(1, 1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h33, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 1, 8'h44, 1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 1, 0, 8'h00, 0, 0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            if (vecs[i].push) push_word(vecs[i].pdata);
            m_ready = vecs[i].ready;
            sample();
            $display("[TB] vec %0d: ready=%0b valid=%0b data=%h last=%0b rd_en=%0b words=%0d",
                     i, m_ready, m_valid, m_data, m_last, fifo_rd_en, words_done);
            check($sformatf("vec%0d_valid", i), {31'b0, m_valid}, {31'b0, vecs[i].v});
            check($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].v});
            if (vecs[i].v) check($sformatf("vec%0d_data", i), {24'b0, m_data}, {24'b0, vecs[i].d});
            check($sformatf("vec%0d_last", i), {31'b0, m_last}, {31'b0, vecs[i].l});
            check($sformatf("vec%0d_rd_en", i), {31'b0, fifo_rd_en}, {31'b0, vecs[i].rd});
            check($sformatf("vec%0d_words", i), {16'b0, words_done}, {16'b0, vecs[i].wd});
            advance();
        end

        // ---------------- empty guard ----------------
        do_reset();
        for (int c = 0; c < 20; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            sample();
            check("empty_rd_en", {31'b0, fifo_rd_en}, 32'd0);
            check("empty_valid", {31'b0, m_valid}, 32'd0);
            advance();
        end
        $display("[TB] empty guard: 20 cycles done");

        // ---------------- reset mid-word ----------------
        do_reset();
        push_word(32'h44332211);
        m_ready = 1'b1;
        sample(); check("mr_pop", {31'b0, fifo_rd_en}, 32'd1); advance();
        sample(); check("mr_b0", {24'b0, m_data}, 32'h11); advance();
        sample(); check("mr_b1", {24'b0, m_data}, 32'h22); advance();
        rstn = 1'b0;
        sample(); check("mr_rd_in_rst", {31'b0, fifo_rd_en}, 32'd0); advance();
        rstn = 1'b1;
        sample();
        check("mr_valid", {31'b0, m_valid}, 32'd0);
        check("mr_data", {24'b0, m_data}, 32'd0);
        check("mr_words", {16'b0, words_done}, 32'd0);
        advance();
        push_word(32'hA1B2C3D4);
        sample(); check("mr2_pop", {31'b0, fifo_rd_en}, 32'd1); advance();
        for (int b = 0; b < 4; b++) begin
            logic [31:0] w;
            w = 32'hA1B2C3D4;
            sample();
            $display("[TB] reset-recovery beat %0d: valid=%0b data=%h last=%0b", b, m_valid, m_data, m_last);
            check("mr2_valid", {31'b0, m_valid}, 32'd1);
            check("mr2_data", {24'b0, m_data}, {24'b0, w[b*8 +: 8]});
            check("mr2_last", {31'b0, m_last}, (b == 3) ? 32'd1 : 32'd0);
            advance();
        end
        sample(); check("mr2_words", {16'b0, words_done}, 32'd1); advance();

        // ---------------- counter wrap (CW=4 instance) ----------------
        do_reset();
        for (int k = 0; k < 17; k++) push_word(32'h10000000 + 32'(k));
        m_ready = 1'b1;
        begin
            int  nlast = 0;
            bit  prev_last = 0;
            int  cyc = 0;
            while (nlast < 17 || prev_last) begin
                sample();
                if (prev_last && nlast >= 15) begin
                    $display("[TB] wrap: word %0d words_done_w=%0d", nlast, words_done_w);
                    check($sformatf("wrap_after_%0d", nlast), {28'b0, words_done_w}, 32'(nlast % 16));
                end
                prev_last = m_valid && m_ready && m_last;
                if (prev_last) nlast++;
                advance();
                cyc++;
                if (cyc > 200) begin
                    check("wrap_timeout", 32'(nlast), 32'd17);
                    break;
                end
            end
        end

        // ---------------- random traffic ----------------
        do_reset();
        begin
            logic [7:0]  sb[$];
            int          pushed = 0;
            int          beats = 0;
            int          cyc = 0;
            bit          stall = 0;
            logic [7:0]  st_data = 0;
            logic        st_last = 0;
            while (beats < 4000) begin
                if (pushed < 1000 && $urandom_range(0, 5) == 0) begin
                    logic [31:0] w;
                    w = $urandom;
                    push_word(w);
                    for (int b = 0; b < 4; b++) sb.push_back(w[b*8 +: 8]);
                    pushed++;
                end
                m_ready = ($urandom_range(0, 3) != 0);
                sample();
                if (stall) begin
                    check("rnd_stall_valid", {31'b0, m_valid}, 32'd1);
                    check("rnd_stall_data", {24'b0, m_data}, {24'b0, st_data});
                    check("rnd_stall_last", {31'b0, m_last}, {31'b0, st_last});
                end
                if (fifo_empty) check("rnd_no_underflow", {31'b0, fifo_rd_en}, 32'd0);
                stall = m_valid && !m_ready;
                st_data = m_data;
                st_last = m_last;
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        check("rnd_unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        logic [7:0] e;
                        e = sb.pop_front();
                        check("rnd_data", {24'b0, m_data}, {24'b0, e});
                        check("rnd_last", {31'b0, m_last}, ((beats % 4) == 3) ? 32'd1 : 32'd0);
                    end
                    beats++;
                end
                advance();
                cyc++;
                if (cyc > 40000) begin
                    check("rnd_timeout_beats", 32'(beats), 32'd4000);
                    break;
                end
            end
            sample();
            $display("[TB] random: %0d words pushed, %0d beats, words_done=%0d wrap=%0d",
                     pushed, beats, words_done, words_done_w);
            check("rnd_words", {16'b0, words_done}, 32'd1000);
            check("rnd_words_w", {28'b0, words_done_w}, 32'(1000 % 16));
            check("rnd_idle", {31'b0, m_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sm_fifo_width_down.md
# sm_fifo_width_down

Read-side drain stage placed directly downstream of the team's synchronous FIFO. It pops DW-bit words from the FIFO's show-ahead read port (data valid combinationally while not empty, pop on rd_en) and re-emits each word as DW/OW narrower beats on a valid/ready stream, least-significant slice first. It runs at full throughput: one OW-bit beat per clock while the FIFO has data and the sink is ready.

## Interface
Parameters:
- DW, 32, FIFO word width; must be an integer multiple of OW.
- OW, 8, output beat width; RATIO = DW/OW must be ≥ 2.
- CW, 16, width of the word counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DW  FIFO head word; valid while fifo_empty=0.
- fifo_rd_en  output  1  pop request to the FIFO (combinational).
- m_valid  output  1  output beat valid.
- m_ready  input  1  sink ready.
- m_data  output  OW  output beat.
- m_last  output  1  marks the last beat of a word.
- words_done  output  CW  count of fully transmitted words; wraps modulo 2^CW.
- busy  output  1  a word is held (equals m_valid).

## Operation
- Internal state:
  - hold_q[DW-1:0]: the held word.
  - beat_q: beat index, $clog2(RATIO) bits, range 0..RATIO-1.
  - state_q: one of EMPTY or SEND.
- Define `take = m_valid & m_ready` and `last_take = take & (beat_q == RATIO-1)`.
- fifo_rd_en = rstn & ~fifo_empty & (state_q==EMPTY | last_take).
  - fifo_rd_en is never asserted while fifo_empty=1 or during reset.
- FSM:
  - EMPTY, fifo_rd_en=1: hold_q ← fifo_data, beat_q ← 0, go to SEND.
  - EMPTY, fifo_rd_en=0: stay in EMPTY.
  - SEND, take and not last_take: beat_q ← beat_q+1.
  - SEND, last_take with fifo_rd_en=1: hold_q ← fifo_data, beat_q ← 0, stay in SEND (back-to-back).
  - SEND, last_take with fifo_rd_en=0: go to EMPTY.
  - SEND, no take: hold everything.
- Outputs:
  - m_valid = (state_q==SEND).
  - m_data = hold_q[beat_q*OW +: OW].
  - m_last = m_valid & (beat_q==RATIO-1).
- words_done increments by 1 on every last_take and wraps from 2^CW-1 to 0.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_last stay stable. The block never deasserts m_valid without a take.
- m_ready is ignored in EMPTY. The block tolerates m_ready toggling on any cycle.
- Reset:
  - state_q=EMPTY, hold_q=0, beat_q=0, words_done=0.
  - Resulting outputs: m_valid=0, m_last=0, m_data=0, busy=0, fifo_rd_en=0.
- Reset mid-word: the held word is discarded with no further beats, and words_done is not incremented. The FIFO is reset on the same rstn, so no pop is lost.

## Timing
- Latency: pop in cycle N (fifo_rd_en=1 at edge N) gives the first beat with m_valid=1 in cycle N+1.
- A word with m_ready held high occupies RATIO consecutive cycles.
- The next word's first beat follows the previous m_last beat with zero bubble, provided the FIFO is non-empty in the last_take cycle.
- fifo_rd_en depends combinationally on m_ready and fifo_empty. There is no combinational path from fifo_data to any output.
- words_done updates in the cycle after last_take.

## Test plan
- Single word, DW=32/OW=8. Write 0x44332211 to an empty FIFO, m_ready=1.
  - Expect one pop, then beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
  - m_last=1 only on 0x44; words_done=1; then m_valid=0 and busy=0.
- Back-to-back. Preload 0xDDCCBBAA and 0x04030201, m_ready=1.
  - Expect 8 consecutive beats AA BB CC DD 01 02 03 04 with no bubble.
  - The second pop coincides with the DD take; words_done=2.
- Backpressure. Same single word, with m_ready=0 on cycles 2–4 after the first beat.
  - m_data holds 0x22 and m_valid holds 1 throughout the stall.
  - Sequence and m_last are unchanged.
  - fifo_rd_en=0 on every cycle until the 0x44 take.
- Empty guard. FIFO empty for 20 cycles with m_ready random.
  - fifo_rd_en=0 and m_valid=0 on every cycle.
  - Also run FIFO underflow-free random traffic (1000 words, random m_ready, random write gaps).
  - The scoreboard must match every byte and every m_last, and words_done must equal 1000 mod 2^CW.
- Reset mid-word. Assert rstn=0 for 1 cycle after beat 0x22 is taken.
  - The next cycle shows m_valid=0, m_data=0, words_done=0.
  - The next word written afterwards drains correctly from its first byte.
- Counter wrap. CW=4, send 17 words.
  - words_done reads 15 after word 15, 0 after word 16, and 1 after word 17.
